// File: rtl/aes_arbiter.sv
// Two-requester round-robin front end for a single AES core.
// One job in flight: grant -> issue to core -> wait (with timeout) -> respond.
// Keeps a one-entry key cache so the core only reloads its key when it changes.
module aes_arbiter #(
  parameter int unsigned DATA_LEN = 128,
  parameter int unsigned KEY_LEN  = 128,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  // requester 0
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_LEN-1:0] req0_plain,
  input  logic [KEY_LEN-1:0]  req0_key,
  // requester 1
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_LEN-1:0] req1_plain,
  input  logic [KEY_LEN-1:0]  req1_key,
  // responses
  output logic                resp0_valid,
  output logic                resp1_valid,
  output logic [DATA_LEN-1:0] resp_data,
  output logic                resp_err,
  output logic                busy,
  // AES core side
  output logic                core_data_valid_in,
  output logic [DATA_LEN-1:0] core_plain_text,
  output logic                core_key_valid_in,
  output logic [KEY_LEN-1:0]  core_cipher_key,
  input  logic                core_data_valid_out,
  input  logic [DATA_LEN-1:0] core_cipher_text
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] plain_q, plain_d;
  logic [KEY_LEN-1:0]  key_q, key_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic [KEY_LEN-1:0]  cache_key_q, cache_key_d;
  logic                cache_vld_q, cache_vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_LEN-1:0] resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic any_req_c;
  logic grant_id_c;
  logic key_load_c;
  logic cnt_last_c;

  // Round-robin pick: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    any_req_c  = req0_valid | req1_valid;
    grant_id_c = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  end

  // Key reload needed when the cache is empty or holds a different key.
  always_comb begin
    key_load_c = ~cache_vld_q | (key_q != cache_key_q);
    cnt_last_c = (cnt_q == CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_data_valid_out || cnt_last_c) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; all forced low during reset.
  always_comb begin
    req0_ready         = 1'b0;
    req1_ready         = 1'b0;
    resp0_valid        = 1'b0;
    resp1_valid        = 1'b0;
    core_data_valid_in = 1'b0;
    core_key_valid_in  = 1'b0;
    busy               = 1'b0;
    if (!reset) begin
      busy = (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          req0_ready = any_req_c & ~grant_id_c;
          req1_ready = any_req_c &  grant_id_c;
        end
        ST_ISSUE: begin
          core_data_valid_in = 1'b1;
          core_key_valid_in  = key_load_c;
        end
        ST_WAIT: begin
        end
        ST_RESP: begin
          resp0_valid = ~id_q;
          resp1_valid =  id_q;
        end
        default: begin
        end
      endcase
    end
  end

  // Datapath next values: job capture, key cache, timeout counter, response.
  always_comb begin
    plain_d     = plain_q;
    key_d       = key_q;
    id_d        = id_q;
    last_d      = last_q;
    cache_key_d = cache_key_q;
    cache_vld_d = cache_vld_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          plain_d = grant_id_c ? req1_plain : req0_plain;
          key_d   = grant_id_c ? req1_key   : req0_key;
          id_d    = grant_id_c;
          last_d  = grant_id_c;
        end
      end
      ST_ISSUE: begin
        cnt_d       = '0;
        cache_key_d = key_q;
        cache_vld_d = 1'b1;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (core_data_valid_out) begin
          // A result on the final allowed cycle still counts as success.
          resp_data_d = core_cipher_text;
          resp_err_d  = 1'b0;
        end else if (cnt_last_c) begin
          // Core state is unknown after a timeout, so force a key reload next time.
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          cache_vld_d = 1'b0;
        end
      end
      ST_RESP: begin
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      plain_q     <= '0;
      key_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      plain_q     <= plain_d;
      key_q       <= key_d;
      id_q        <= id_d;
      last_q      <= last_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign core_plain_text = plain_q;
  assign core_cipher_key = key_q;
  assign resp_data       = resp_data_q;
  assign resp_err        = resp_err_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// Bench for aes_arbiter: directed scenarios followed by randomized jobs,
// checked against a job-level model (grant order, key cache, expected response).
module tb_aes_arbiter;

  localparam int unsigned DL = 128;
  localparam int unsigned KL = 128;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DL-1:0] req0_plain, req1_plain;
  logic [KL-1:0] req0_key, req1_key;
  logic          resp0_valid, resp1_valid;
  logic [DL-1:0] resp_data;
  logic          resp_err;
  logic          busy;
  logic          core_data_valid_in;
  logic [DL-1:0] core_plain_text;
  logic          core_key_valid_in;
  logic [KL-1:0] core_cipher_key;
  logic          core_data_valid_out;
  logic [DL-1:0] core_cipher_text;

  always #5 clk = ~clk;

  aes_arbiter #(.DATA_LEN(DL), .KEY_LEN(KL), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req0_valid          (req0_valid),
    .req0_ready          (req0_ready),
    .req0_plain          (req0_plain),
    .req0_key            (req0_key),
    .req1_valid          (req1_valid),
    .req1_ready          (req1_ready),
    .req1_plain          (req1_plain),
    .req1_key            (req1_key),
    .resp0_valid         (resp0_valid),
    .resp1_valid         (resp1_valid),
    .resp_data           (resp_data),
    .resp_err            (resp_err),
    .busy                (busy),
    .core_data_valid_in  (core_data_valid_in),
    .core_plain_text     (core_plain_text),
    .core_key_valid_in   (core_key_valid_in),
    .core_cipher_key     (core_cipher_key),
    .core_data_valid_out (core_data_valid_out),
    .core_cipher_text    (core_cipher_text)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Job-level model of the arbiter.
  bit            m_last;
  bit            m_cvld;
  logic [KL-1:0] m_ckey;
  logic [DL-1:0] m_plain;
  logic [KL-1:0] m_key;
  logic [DL-1:0] m_rdata;
  bit            m_rerr;

  logic [DL-1:0] fips_p, fips_c;
  logic [KL-1:0] fips_k;
  logic [KL-1:0] key_pool [3];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    m_cvld  = 1'b0;
    m_ckey  = '0;
    m_plain = '0;
    m_key   = '0;
    m_rdata = '0;
    m_rerr  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    core_data_valid_out = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_strobes", 128'({resp1_valid, resp0_valid, core_data_valid_in, core_key_valid_in}), 128'(0));
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_err", 128'(resp_err), 128'(0));
    chk("rst_core_plain", core_plain_text, '0);
    chk("rst_core_key", core_cipher_key, '0);
  endtask

  // One complete job. delay = WAIT cycle on which the core answers (<0 or >=TO: never).
  task automatic do_job(input bit v0, input bit v1, input bit hold, input bit junk,
                        input logic [DL-1:0] p0, input logic [KL-1:0] k0,
                        input logic [DL-1:0] p1, input logic [KL-1:0] k1,
                        input int delay, input logic [DL-1:0] cipher);
    bit            w;
    bit            exp_kl;
    bit            timed_out;
    logic [DL-1:0] pw;
    logic [KL-1:0] kw;
    @(negedge clk);
    req0_valid = v0;
    req1_valid = v1;
    req0_plain = p0;
    req0_key   = k0;
    req1_plain = p1;
    req1_key   = k1;
    core_data_valid_out = junk;
    core_cipher_text    = rnd128();
    #1;
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_resp", 128'({resp1_valid, resp0_valid}), 128'(0));
    chk("hold_resp_data", resp_data, m_rdata);
    chk("hold_resp_err", 128'(resp_err), 128'(m_rerr));
    chk("hold_core_plain", core_plain_text, m_plain);
    chk("hold_core_key", core_cipher_key, m_key);
    w = (v0 && v1) ? ~m_last : v1;
    chk("grant", 128'({req1_ready, req0_ready}), 128'(w ? 2'b10 : 2'b01));
    m_last = w;
    pw = w ? p1 : p0;
    kw = w ? k1 : k0;
    exp_kl = !m_cvld || (m_ckey != kw);

    @(negedge clk);
    if (!hold) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    #1;
    chk("issue_strobe", 128'(core_data_valid_in), 128'(1));
    chk("issue_keyload", 128'(core_key_valid_in), 128'(exp_kl));
    chk("issue_plain", core_plain_text, pw);
    chk("issue_key", core_cipher_key, kw);
    chk("issue_ready_busy", 128'({req1_ready, req0_ready, busy}), 128'(3'b001));
    m_cvld  = 1'b1;
    m_ckey  = kw;
    m_plain = pw;
    m_key   = kw;

    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      core_data_valid_out = (k == delay);
      core_cipher_text    = (k == delay) ? cipher : rnd128();
      #1;
      chk("wait_state", 128'({core_data_valid_in, core_key_valid_in, req1_ready, req0_ready,
                              resp1_valid, resp0_valid, busy}), 128'(7'b0000001));
      if (k == delay) break;
    end
    timed_out = (delay < 0) || (delay >= TO);

    @(negedge clk);
    // A late core strobe during the response cycle must be ignored.
    core_data_valid_out = timed_out && junk;
    core_cipher_text    = rnd128();
    #1;
    if (timed_out) begin
      m_rdata = '0;
      m_rerr  = 1'b1;
      m_cvld  = 1'b0;
    end else begin
      m_rdata = cipher;
      m_rerr  = 1'b0;
    end
    chk("resp_valid", 128'({resp1_valid, resp0_valid}), 128'(w ? 2'b10 : 2'b01));
    chk("resp_data", resp_data, m_rdata);
    chk("resp_err", 128'(resp_err), 128'(m_rerr));
    chk("resp_busy_ready", 128'({busy, req1_ready, req0_ready}), 128'(3'b100));
  endtask

  initial begin
    bit            rv0, rv1;
    int            sel, dly, r;
    logic [DL-1:0] c;
    fips_p = 128'h3243f6a8885a308d313198a2e0370734;
    fips_k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_c = 128'h3925841d02dc09fbdc118597196a0b32;
    key_pool[0] = fips_k;
    key_pool[1] = rnd128();
    key_pool[2] = rnd128();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_plain = '0;
    req1_plain = '0;
    req0_key   = '0;
    req1_key   = '0;
    core_data_valid_out = 1'b0;
    core_cipher_text    = '0;
    model_reset();
    do_reset();

    // Known-answer job on requester 0 (key load), then repeated on requester 1 (cache hit).
    do_job(1'b1, 1'b0, 1'b0, 1'b0, fips_p, fips_k, '0, '0, 3, fips_c);
    do_job(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, fips_p, fips_k, 2, fips_c);

    // Both requesters held valid from reset: alternating grants starting with 0.
    do_reset();
    for (int j = 0; j < 4; j++) begin
      do_job(1'b1, 1'b1, 1'b1, 1'b0, rnd128(), key_pool[1], rnd128(), key_pool[2], j, rnd128());
    end

    // Core never answers, late strobe in response cycle; next job must reload its key.
    do_job(1'b1, 1'b0, 1'b0, 1'b1, fips_p, fips_k, '0, '0, -1, '0);
    do_job(1'b1, 1'b0, 1'b0, 1'b0, fips_p, fips_k, '0, '0, 0, fips_c);

    // Result on the final allowed cycle is a success.
    do_job(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, rnd128(), fips_k, TO - 1, fips_c);

    // Reset while waiting on the core: job aborted, late result ignored, key reloaded.
    @(negedge clk);
    req0_valid = 1'b1;
    req0_plain = fips_p;
    req0_key   = fips_k;
    #1;
    chk("abort_grant", 128'({req1_ready, req0_ready}), 128'(2'b01));
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    core_data_valid_out = 1'b1;
    core_cipher_text    = fips_c;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_resp", 128'({resp1_valid, resp0_valid}), 128'(0));
    chk("abort_resp_data", resp_data, '0);
    @(negedge clk);
    core_data_valid_out = 1'b0;
    #1;
    chk("abort_late_resp", 128'({resp1_valid, resp0_valid, busy}), 128'(0));
    do_job(1'b1, 1'b0, 1'b0, 1'b0, fips_p, fips_k, '0, '0, 1, fips_c);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      sel = $urandom_range(1, 3);
      rv0 = sel[0];
      rv1 = sel[1];
      r = $urandom_range(0, 9);
      if (r == 0)      dly = -1;
      else if (r == 1) dly = TO - 1;
      else             dly = $urandom_range(0, TO - 1);
      c = rnd128();
      do_job(rv0, rv1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             rnd128(), key_pool[$urandom_range(0, 2)],
             rnd128(), key_pool[$urandom_range(0, 2)], dly, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter DATA_LEN, 128, width of plaintext/ciphertext buses.
REQ-002 Parameter KEY_LEN, 128, width of key buses.
REQ-003 Parameter TIMEOUT, 64, max cycles waited for core result (legal range 2..255).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reqN_valid  input  1  (N=0,1) requester N presents an encryption job.
REQ-007 reqN_ready  output  1  (N=0,1) job from requester N accepted this cycle.
REQ-008 reqN_plain  input  DATA_LEN  (N=0,1) plaintext of requester N.
REQ-009 reqN_key  input  KEY_LEN  (N=0,1) cipher key of requester N.
REQ-010 respN_valid  output  1  (N=0,1) one-cycle result strobe to requester N.
REQ-011 resp_data  output  DATA_LEN  ciphertext, valid with respN_valid.
REQ-012 resp_err  output  1  timeout flag, valid with respN_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 core_data_valid_in  output  1  plaintext strobe to AES core.
REQ-015 core_plain_text  output  DATA_LEN  plaintext to core.
REQ-016 core_key_valid_in  output  1  key-load strobe to core.
REQ-017 core_cipher_key  output  KEY_LEN  key to core.
REQ-018 core_data_valid_out  input  1  core result strobe.
REQ-019 core_cipher_text  input  DATA_LEN  core result.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one job in flight at a time.
REQ-021 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle, register its plain/key and id, go ISSUE.
REQ-022 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; single valid wins unconditionally.
REQ-023 ISSUE: SHALL assert core_data_valid_in for exactly one cycle with registered plain/key, clear timeout counter, go WAIT.
REQ-024 Key cache: core_key_valid_in SHALL assert in ISSUE only if no key is cached or registered key differs from cached key; cached key updates to the issued key.
REQ-025 core_plain_text/core_cipher_key SHALL hold registered values from ISSUE until the next grant.
REQ-026 WAIT: on core_data_valid_out, SHALL register core_cipher_text, err=0, go RESP.
REQ-027 WAIT: counter increments each cycle; on reaching TIMEOUT without result, SHALL set err=1, resp_data=0, invalidate key cache, go RESP.
REQ-028 core_data_valid_out in same cycle counter reaches TIMEOUT SHALL be treated as success.
REQ-029 core_data_valid_out outside WAIT SHALL be ignored with no state effect.
REQ-030 RESP: SHALL assert respN_valid for granted id only, for one cycle, then go IDLE; no backpressure on responses.
REQ-031 reqN_ready SHALL be 0 in all states except IDLE; requests held valid while busy SHALL wait.
REQ-032 Latency: grant at cycle T, core strobe at T+1, core result at cycle C, respN_valid at C+1; minimum next grant at C+2.
REQ-033 resp_data/resp_err SHALL hold last values between responses.

Reset
REQ-034 On reset SHALL enter IDLE; all valid/ready/strobe outputs 0, busy 0, resp_data 0, resp_err 0, core buses 0.
REQ-035 Reset SHALL invalidate key cache, clear counter, set last-grant to 1 so requester 0 wins first tie.
REQ-036 Reset mid-job SHALL abort it with no response; a late core_data_valid_out is ignored per REQ-029.

Verification
REQ-037 req0 plain 3243f6a8885a308d313198a2e0370734 key 2b7e151628aed2a6abf7158809cf4f3c, core model -> core_key_valid_in=1, resp0_valid with 3925841d02dc09fbdc118597196a0b32, err 0.
REQ-038 Repeat same job on req1 -> core_key_valid_in=0 (cache hit), resp1_valid with same ciphertext, resp0_valid stays 0.
REQ-039 Both valid continuously after reset, 4 jobs -> grant order 0,1,0,1; each resp to correct requester.
REQ-040 Core model never responds -> resp_err=1, resp_data=0 exactly TIMEOUT cycles after WAIT entry; next job reloads key.
REQ-041 Reset asserted in WAIT, core then responds -> no respN_valid, busy=0, next job issues key load.
REQ-042 Core result arriving on TIMEOUT cycle -> err=0, ciphertext returned.
